debug_step_ctrl: RTL and testbench

//  Clock-enable based single/multi-step debug controller for the DAQ firmware.

---
 rtl/debug_pkg.sv | 13 +
 rtl/debug_edge_sync.sv | 29 ++
 rtl/okWireOut.sv | 12 +
 rtl/debug_step_ctrl.sv | 134 +++++++++++++
 tb/tb_debug_step_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared state encoding and endpoint defaults for the clock-enable stepping controller.
package debug_pkg;
  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam logic [7:0] EP_BASE_DEFAULT = 8'h20;
  localparam int         WORD_W          = 16;
  localparam int         EH_W            = 65;
  localparam int         HE_W            = 113;
endpackage

// File: rtl/debug_edge_sync.sv
// Two-flop synchroniser for an asynchronous host level, followed by a registered
// rising-edge pulse (pulse appears on the third clock edge after the level rises).
module debug_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_pulse
);
  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/okWireOut.sv
// Behavioural stand-in for the vendor wireout endpoint: presents the endpoint
// address and data word on its endpoint-to-host bus.
module okWireOut (
  input  logic [112:0] okHE,
  output logic [64:0]  okEH,
  input  logic [7:0]   ep_addr,
  input  logic [31:0]  ep_datain
);
  logic w_unused;
  assign w_unused = ^okHE;
  assign okEH     = {25'd0, ep_addr, ep_datain};
endmodule

// File: rtl/debug_step_ctrl.sv
// Clock-enable stepping controller: free run, halt, N-cycle bursts, cycle-count
// breakpoint, and halt-time snapshots of debug words exported over wireouts.
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int          DEBUG_SIZE = 4,
  parameter int          CNT_WIDTH  = 32,
  parameter int          STEP_WIDTH = 16,
  parameter logic [7:0]  EP_BASE    = EP_BASE_DEFAULT
) (
  input  logic                             phy_clk,
  input  logic                             reset,
  input  logic                             debug_enable,
  input  logic                             step_req,
  input  logic [STEP_WIDTH-1:0]            step_count,
  input  logic                             break_enable,
  input  logic [CNT_WIDTH-1:0]             break_value,
  output logic                             sys_clk_en,
  output logic                             halted,
  output logic                             break_hit,
  output logic [CNT_WIDTH-1:0]             cycle_counter,
  input  logic [DEBUG_SIZE*WORD_W-1:0]     debug_wireout,
  input  logic [HE_W-1:0]                  okHE,
  output logic [(DEBUG_SIZE+1)*EH_W-1:0]   okEHx
);
  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [STEP_WIDTH-1:0]         r_remaining;
  logic [STEP_WIDTH-1:0]         w_remaining_nxt;
  logic                          r_sys_clk_en;
  logic                          r_halted;
  logic                          r_break_hit;
  logic [CNT_WIDTH-1:0]          r_cycle_counter;
  logic [DEBUG_SIZE*WORD_W-1:0]  r_snap;
  logic                          w_step_pulse;
  logic                          w_brk;
  logic [11:0]                   w_cnt_lo;
  logic [WORD_W-1:0]             w_status;

  debug_edge_sync u_step_sync (
    .clk     (phy_clk),
    .reset   (reset),
    .i_async (step_req),
    .o_pulse (w_step_pulse)
  );

  // Match on the value the counter is about to take, so it freezes exactly at break_value.
  assign w_brk = break_enable && r_sys_clk_en &&
                 ((r_cycle_counter + CNT_WIDTH'(1)) == break_value);

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    case (r_state)
      HALT: begin
        if (w_step_pulse) begin
          w_state_nxt     = STEP;
          w_remaining_nxt = (step_count == '0) ? STEP_WIDTH'(1) : step_count;
        end else if (!debug_enable && !r_break_hit) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (debug_enable || w_brk) w_state_nxt = HALT;
      end
      STEP: begin
        if (w_brk || r_remaining <= STEP_WIDTH'(1)) begin
          w_state_nxt     = HALT;
          w_remaining_nxt = '0;
        end else begin
          w_remaining_nxt = r_remaining - STEP_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt     = HALT;
        w_remaining_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      r_state         <= HALT;
      r_remaining     <= '0;
      r_sys_clk_en    <= 1'b0;
      r_halted        <= 1'b1;
      r_break_hit     <= 1'b0;
      r_cycle_counter <= '0;
      r_snap          <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_remaining  <= w_remaining_nxt;
      r_sys_clk_en <= (w_state_nxt == RUN) || (w_state_nxt == STEP);
      r_halted     <= (w_state_nxt == HALT);
      if (!break_enable)  r_break_hit <= 1'b0;
      else if (w_brk)     r_break_hit <= 1'b1;
      if (r_sys_clk_en) r_cycle_counter <= r_cycle_counter + CNT_WIDTH'(1);
      if (w_state_nxt == HALT && r_state != HALT) r_snap <= debug_wireout;
    end
  end

  assign sys_clk_en    = r_sys_clk_en;
  assign halted        = r_halted;
  assign break_hit     = r_break_hit;
  assign cycle_counter = r_cycle_counter;

  generate
    if (CNT_WIDTH >= 12) begin : g_cnt_wide
      assign w_cnt_lo = r_cycle_counter[11:0];
    end else begin : g_cnt_narrow
      assign w_cnt_lo = {{(12-CNT_WIDTH){1'b0}}, r_cycle_counter};
    end
  endgenerate

  assign w_status = {w_cnt_lo, r_break_hit, r_halted, r_state};

  for (genvar i = 0; i < DEBUG_SIZE; i++) begin : g_dbg
    logic [WORD_W-1:0] w_word;
    assign w_word = r_halted ? r_snap[WORD_W*i +: WORD_W] : debug_wireout[WORD_W*i +: WORD_W];
    okWireOut u_wo (
      .okHE      (okHE),
      .okEH      (okEHx[EH_W*i +: EH_W]),
      .ep_addr   (EP_BASE + 8'(i)),
      .ep_datain ({16'd0, w_word})
    );
  end

  okWireOut u_wo_status (
    .okHE      (okHE),
    .okEH      (okEHx[EH_W*DEBUG_SIZE +: EH_W]),
    .ep_addr   (EP_BASE + 8'(DEBUG_SIZE)),
    .ep_datain ({16'd0, w_status})
  );
endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl: directed steps with randomized burst
// lengths and debug words, expectations computed from the stepping rules.
module tb_debug_step_ctrl;
  localparam int DS = 4;
  localparam int CW = 32;
  localparam int SW = 16;

  logic                  phy_clk = 1'b0;
  logic                  reset, debug_enable, step_req, break_enable;
  logic [SW-1:0]         step_count;
  logic [CW-1:0]         break_value;
  logic                  sys_clk_en, halted, break_hit;
  logic [CW-1:0]         cycle_counter;
  logic [DS*16-1:0]      debug_wireout;
  logic [112:0]          okHE;
  logic [(DS+1)*65-1:0]  okEHx;

  logic                  reset4, debug_enable4, step_req4, break_enable4;
  logic [SW-1:0]         step_count4;
  logic [3:0]            break_value4;
  logic                  sys_clk_en4, halted4, break_hit4;
  logic [3:0]            cycle_counter4;
  logic [(DS+1)*65-1:0]  okEHx4;

  int                    n_cmp = 0;
  int                    n_fail = 0;
  logic [64:0]           exp_q[$];

  always #5 phy_clk = ~phy_clk;

  debug_step_ctrl #(.DEBUG_SIZE(DS), .CNT_WIDTH(CW), .STEP_WIDTH(SW), .EP_BASE(8'h20)) u_dut (
    .phy_clk(phy_clk), .reset(reset), .debug_enable(debug_enable), .step_req(step_req),
    .step_count(step_count), .break_enable(break_enable), .break_value(break_value),
    .sys_clk_en(sys_clk_en), .halted(halted), .break_hit(break_hit),
    .cycle_counter(cycle_counter), .debug_wireout(debug_wireout), .okHE(okHE), .okEHx(okEHx)
  );

  debug_step_ctrl #(.DEBUG_SIZE(DS), .CNT_WIDTH(4), .STEP_WIDTH(SW), .EP_BASE(8'h20)) u_dut4 (
    .phy_clk(phy_clk), .reset(reset4), .debug_enable(debug_enable4), .step_req(step_req4),
    .step_count(step_count4), .break_enable(break_enable4), .break_value(break_value4),
    .sys_clk_en(sys_clk_en4), .halted(halted4), .break_hit(break_hit4),
    .cycle_counter(cycle_counter4), .debug_wireout(debug_wireout), .okHE(okHE), .okEHx(okEHx4)
  );

  task automatic tick();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    logic [64:0] e;
    exp_q.push_back(exp_v);
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  function automatic logic [64:0] eh_word(input int ch, input logic [15:0] w);
    return {25'd0, 8'(8'h20 + ch), 16'd0, w};
  endfunction

  function automatic logic [15:0] status_word(input logic [31:0] c, input logic bh,
                                              input logic h, input logic [1:0] st);
    return {c[11:0], bh, h, st};
  endfunction

  function automatic logic [64:0] eh_ch(input int ch);
    return okEHx[65*ch +: 65];
  endfunction

  function automatic logic [64:0] eh4_ch(input int ch);
    return okEHx4[65*ch +: 65];
  endfunction

  // One step_req pulse; optional second rising edge while the burst is still running.
  task automatic burst(input int sc, input bit repulse, output int n_en);
    int win;
    win        = ((sc == 0) ? 1 : sc) + 14;
    step_count = SW'(sc);
    step_req   = 1'b1;
    n_en       = 0;
    for (int i = 0; i < win; i++) begin
      if (i == 1) step_req = 1'b0;
      if (repulse && i == 2) step_req = 1'b1;
      if (repulse && i == 4) step_req = 1'b0;
      tick();
      if (sys_clk_en) n_en++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t, sc, m_cnt, ch;
    logic [DS*16-1:0] dw, dw_old;

    reset = 1'b1; debug_enable = 1'b0; step_req = 1'b0; step_count = '0;
    break_enable = 1'b0; break_value = '0;
    reset4 = 1'b1; debug_enable4 = 1'b0; step_req4 = 1'b0; step_count4 = '0;
    break_enable4 = 1'b0; break_value4 = '0;
    debug_wireout = {$urandom(), $urandom()};
    okHE = 113'({$urandom(), $urandom(), $urandom(), $urandom()});

    // Reset state, then free run
    repeat (2) tick();
    reset = 1'b0;
    cmp("rst_en", sys_clk_en, 0);
    cmp("rst_halted", halted, 1);
    cmp("rst_cnt", cycle_counter, 0);
    cmp("rst_bh", break_hit, 0);
    cmp("rst_status", eh_ch(4), eh_word(4, 16'h0004));
    tick();
    cmp("run_en", sys_clk_en, 1);
    cmp("run_cnt0", cycle_counter, 0);
    tick();
    cmp("run_cnt1", cycle_counter, 1);
    tick();
    cmp("run_cnt2", cycle_counter, 2);
    n = $urandom_range(3, 10);
    repeat (n) tick();
    m_cnt = 2 + n;
    cmp("run_cntN", cycle_counter, m_cnt);
    cmp("run_status", eh_ch(4), eh_word(4, status_word(m_cnt, 1'b0, 1'b0, 2'd1)));

    // Halt request lets one more enabled cycle through
    debug_enable = 1'b1;
    tick();
    m_cnt++;
    cmp("halt_cnt", cycle_counter, m_cnt);
    cmp("halt_en", sys_clk_en, 0);
    cmp("halt_halted", halted, 1);

    // Single step with step_count=0
    burst(0, 1'b0, n);
    cmp("step0_cycles", n, 1);
    m_cnt += 1;
    cmp("step0_cnt", cycle_counter, m_cnt);
    cmp("step0_halted", halted, 1);

    // Five-cycle burst, second pulse mid-burst ignored
    burst(5, 1'b1, n);
    cmp("step5_cycles", n, 5);
    m_cnt += 5;
    cmp("step5_cnt", cycle_counter, m_cnt);

    // Random bursts with snapshot checks
    for (int k = 0; k < 6; k++) begin
      sc = $urandom_range(0, 9);
      dw = {$urandom(), $urandom()};
      debug_wireout = dw;
      burst(sc, 1'b0, n);
      cmp("rnd_cycles", n, (sc == 0) ? 1 : sc);
      m_cnt += (sc == 0) ? 1 : sc;
      cmp("rnd_cnt", cycle_counter, m_cnt);
      debug_wireout = {$urandom(), $urandom()};
      tick();
      ch = k % DS;
      cmp("rnd_snap", eh_ch(ch), eh_word(ch, dw[16*ch +: 16]));
    end

    // Breakpoint at 100
    break_value = 32'd100;
    break_enable = 1'b1;
    debug_enable = 1'b0;
    tick();
    t = 0;
    while (!halted && t < 300) begin
      tick();
      t++;
    end
    cmp("brk_timeout", halted, 1);
    cmp("brk_cnt", cycle_counter, 100);
    cmp("brk_hit", break_hit, 1);
    cmp("brk_status", eh_ch(4), eh_word(4, status_word(32'd100, 1'b1, 1'b1, 2'd0)));
    n = 0;
    repeat (8) begin
      tick();
      if (sys_clk_en) n++;
    end
    cmp("brk_hold", n, 0);

    // Stepping out of a break halt does not re-trigger
    burst(3, 1'b0, n);
    cmp("brk_step_cycles", n, 3);
    cmp("brk_step_cnt", cycle_counter, 103);
    cmp("brk_step_bh", break_hit, 1);
    cmp("brk_step_halted", halted, 1);

    break_enable = 1'b0;
    tick();
    cmp("brk_clear_bh", break_hit, 0);
    cmp("brk_clear_halted", halted, 1);
    tick();
    cmp("resume_halted", halted, 0);
    cmp("resume_en", sys_clk_en, 1);
    cmp("resume_cnt", cycle_counter, 103);

    // Snapshot held while halted, live after resume
    dw = {$urandom(), $urandom()};
    dw[15:0] = 16'hA5A5;
    debug_wireout = dw;
    debug_enable = 1'b1;
    tick();
    dw_old = dw;
    dw[15:0] = 16'h1234;
    dw[47:32] = ~dw_old[47:32];
    debug_wireout = dw;
    tick();
    cmp("snap_ch0", eh_ch(0), eh_word(0, 16'hA5A5));
    cmp("snap_ch2", eh_ch(2), eh_word(2, dw_old[47:32]));
    debug_enable = 1'b0;
    tick();
    cmp("live_halted", halted, 0);
    cmp("live_ch0", eh_ch(0), eh_word(0, 16'h1234));
    cmp("live_ch2", eh_ch(2), eh_word(2, dw[47:32]));

    // Reset in the middle of a long burst
    debug_enable = 1'b1;
    tick();
    step_count = 16'd1000;
    step_req = 1'b1;
    tick();
    tick();
    step_req = 1'b0;
    t = 0;
    while (!sys_clk_en && t < 20) begin
      tick();
      t++;
    end
    cmp("long_start", sys_clk_en, 1);
    repeat (9) tick();
    cmp("long_running", sys_clk_en, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("midrst_halted", halted, 1);
    cmp("midrst_en", sys_clk_en, 0);
    cmp("midrst_cnt", cycle_counter, 0);
    cmp("midrst_snap", eh_ch(0), eh_word(0, 16'h0000));
    n = 0;
    repeat (20) begin
      tick();
      if (sys_clk_en) n++;
    end
    cmp("midrst_no_resume", n, 0);

    // Narrow counter wraps
    reset4 = 1'b0;
    tick();
    cmp("w4_cnt0", cycle_counter4, 0);
    repeat (15) tick();
    cmp("w4_cnt15", cycle_counter4, 15);
    tick();
    cmp("w4_wrap", cycle_counter4, 0);
    cmp("w4_status", eh4_ch(4), eh_word(4, status_word(32'd0, 1'b0, 1'b0, 2'd1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
